// File: rtl/bl_ctrl_multi.sv
// bl_ctrl_multi: bit-line DAC/strobe sequencer for set/reset/read with bursts, timeout and abort
module bl_ctrl_multi #(
    parameter int ADDR_W = 5,
    parameter int DAC_W = 8,
    parameter int TMR_W = 8,
    parameter int REP_W = 4,
    parameter int T_PRE = 10,
    parameter int T_ADDR = 10,
    parameter int T_TOUT = 200,
    parameter logic [DAC_W-1:0] V_SET_PRE = 8'h00,
    parameter logic [DAC_W-1:0] V_RST_PRE = 8'h6C,
    parameter logic [DAC_W-1:0] V_RD_PRE = 8'h00,
    parameter logic [DAC_W-1:0] V_SET_OP = 8'h4D,
    parameter logic [DAC_W-1:0] V_RST_OP = 8'h00,
    parameter logic [DAC_W-1:0] V_RD_OP = 8'h08,
    parameter logic [DAC_W-1:0] V_IDLE = 8'h00
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              work_en,
    input  logic              work_mode,
    input  logic              op_mode,
    input  logic [ADDR_W-1:0] bl_addr_in,
    input  logic [REP_W-1:0]  rep_in,
    input  logic              op_down,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [DAC_W-1:0]  bl_digital_vol,
    output logic              bl_dac_lock_en,
    output logic [ADDR_W-1:0] bl_addr,
    output logic              bl_pre_op_en,
    output logic              bl_addr_op_en,
    output logic              bl_assert_en
);
    typedef enum logic [2:0] {IDLE, PRE_OP, ADDR_OP, WAIT, DONE} state_t;
    localparam logic [TMR_W-1:0] TP = TMR_W'(T_PRE);
    localparam logic [TMR_W-1:0] TA = TMR_W'(T_ADDR);
    localparam logic [TMR_W-1:0] TT = TMR_W'(T_TOUT);
    localparam logic [TMR_W-1:0] ONE = TMR_W'(1);
    state_t state, state_n;
    logic mode, mode_n, op, op_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [REP_W-1:0] rep, rep_n;
    logic [1:0] err_n;
    logic [DAC_W-1:0] vol_n;
    logic [ADDR_W-1:0] addr_n;
    logic lock_n, pre_n, aop_n, done_n;
    function automatic logic [DAC_W-1:0] pre_code(input logic m, input logic o);
        return m ? (o ? V_SET_PRE : V_RST_PRE) : V_RD_PRE;
    endfunction
    function automatic logic [DAC_W-1:0] op_code(input logic m, input logic o);
        return m ? (o ? V_SET_OP : V_RST_OP) : V_RD_OP;
    endfunction
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            mode <= 1'b0;
            op <= 1'b0;
            timer <= '0;
            rep <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 2'b00;
            bl_digital_vol <= '0;
            bl_dac_lock_en <= 1'b0;
            bl_addr <= '0;
            bl_pre_op_en <= 1'b0;
            bl_addr_op_en <= 1'b0;
            bl_assert_en <= 1'b0;
        end else begin
            state <= state_n;
            mode <= mode_n;
            op <= op_n;
            timer <= timer_n;
            rep <= rep_n;
            busy <= state_n != IDLE;
            done <= done_n;
            err <= err_n;
            bl_digital_vol <= vol_n;
            bl_dac_lock_en <= lock_n;
            bl_addr <= addr_n;
            bl_pre_op_en <= pre_n;
            bl_addr_op_en <= aop_n;
            bl_assert_en <= aop_n;
        end
    end
    always_comb begin
        state_n = state;
        mode_n = mode;
        op_n = op;
        timer_n = timer;
        rep_n = rep;
        err_n = err;
        vol_n = bl_digital_vol;
        addr_n = bl_addr;
        lock_n = 1'b0;
        pre_n = 1'b0;
        aop_n = 1'b0;
        done_n = 1'b0;
        case (state)
            IDLE: if (work_en) begin
                mode_n = work_mode;
                op_n = op_mode;
                addr_n = bl_addr_in;
                rep_n = rep_in;
                vol_n = pre_code(work_mode, op_mode);
                lock_n = 1'b1;
                timer_n = TP;
                err_n = 2'b00;
                state_n = PRE_OP;
            end
            PRE_OP: if (abort) begin
                err_n = 2'b10;
                state_n = DONE;
            end else if (timer == ONE) begin
                pre_n = 1'b1;
                vol_n = op_code(mode, op);
                lock_n = 1'b1;
                timer_n = TA;
                state_n = ADDR_OP;
            end else timer_n = timer - ONE;
            ADDR_OP: if (abort) begin
                err_n = 2'b10;
                state_n = DONE;
            end else if (timer == ONE) begin
                aop_n = 1'b1;
                timer_n = TT;
                state_n = WAIT;
            end else timer_n = timer - ONE;
            WAIT: if (abort) begin
                err_n = 2'b10;
                state_n = DONE;
            end else if (op_down && rep != '0) begin
                // burst re-arm: stay on the operate code, skip precharge
                rep_n = rep - 1'b1;
                timer_n = TA;
                state_n = ADDR_OP;
            end else if (op_down || timer == ONE) begin
                err_n = op_down ? 2'b00 : 2'b01;
                state_n = DONE;
            end else timer_n = timer - ONE;
            DONE: begin
                done_n = 1'b1;
                vol_n = V_IDLE;
                lock_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bl_ctrl_multi.sv
// tb_bl_ctrl_multi: scoreboard bench with hand-timed strobe events for bl_ctrl_multi
module tb_bl_ctrl_multi;
    logic sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic work_en = 1'b0, work_mode = 1'b0, op_mode = 1'b0, op_down = 1'b0, abort = 1'b0;
    logic [4:0] bl_addr_in = '0;
    logic [3:0] rep_in = '0;
    logic busy, done, bl_dac_lock_en, bl_pre_op_en, bl_addr_op_en, bl_assert_en;
    logic [1:0] err;
    logic [7:0] bl_digital_vol;
    logic [4:0] bl_addr;
    int cyc = 0, checks = 0, errors = 0;
    typedef struct {
        int cyc;
        logic [4:0] st;
        logic [7:0] vol;
        logic [1:0] err;
        logic busy;
        logic [4:0] addr;
    } ev_t;
    ev_t q[$];
    localparam logic [4:0] L = 5'b10000, LP = 5'b11000, AA = 5'b00110, LD = 5'b10001;

    bl_ctrl_multi dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .work_en(work_en), .work_mode(work_mode),
        .op_mode(op_mode), .bl_addr_in(bl_addr_in), .rep_in(rep_in), .op_down(op_down),
        .abort(abort), .busy(busy), .done(done), .err(err), .bl_digital_vol(bl_digital_vol),
        .bl_dac_lock_en(bl_dac_lock_en), .bl_addr(bl_addr), .bl_pre_op_en(bl_pre_op_en),
        .bl_addr_op_en(bl_addr_op_en), .bl_assert_en(bl_assert_en)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void push(int c, logic [4:0] st, logic [7:0] v, logic [1:0] e, logic b, logic [4:0] a);
        q.push_back('{c, st, v, e, b, a});
    endfunction

    // monitor: any strobe is an event that must match the head of the queue
    always @(negedge sys_clk) begin
        logic [4:0] st;
        ev_t x;
        st = {bl_dac_lock_en, bl_pre_op_en, bl_addr_op_en, bl_assert_en, done};
        while (q.size() != 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event cyc=%0d act=none exp_st=%b", q[0].cyc, q[0].st);
            void'(q.pop_front());
        end
        if (st != 5'b0) begin
            checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d act_st=%b exp=none", cyc, st);
            end else begin
                x = q.pop_front();
                if (st != x.st || bl_digital_vol != x.vol || err != x.err || busy != x.busy || bl_addr != x.addr) begin
                    errors++;
                    $display("FAIL event cyc=%0d act st=%b vol=%h err=%b busy=%b addr=%h exp st=%b vol=%h err=%b busy=%b addr=%h",
                        cyc, st, bl_digital_vol, err, busy, bl_addr, x.st, x.vol, x.err, x.busy, x.addr);
                end
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge sys_clk);
    endtask

    task automatic cmd(input logic wm, input logic om, input logic [4:0] a, input logic [3:0] r, output int e0);
        work_en = 1'b1;
        work_mode = wm;
        op_mode = om;
        bl_addr_in = a;
        rep_in = r;
        e0 = cyc + 1;
    endtask

    task automatic drop(input int e0);
        wait_to(e0);
        work_en = 1'b0;
    endtask

    task automatic od_at(input int x);
        wait_to(x - 1);
        op_down = 1'b1;
        wait_to(x);
        op_down = 1'b0;
    endtask

    task automatic abort_at(input int x);
        wait_to(x - 1);
        abort = 1'b1;
        wait_to(x);
        abort = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if ({busy, done, err, bl_digital_vol, bl_dac_lock_en, bl_addr, bl_pre_op_en, bl_addr_op_en, bl_assert_en} != '0) begin
            errors++;
            $display("FAIL %s act busy=%b done=%b err=%b vol=%h lock=%b addr=%h pre=%b aop=%b asrt=%b exp all zero",
                name, busy, done, err, bl_digital_vol, bl_dac_lock_en, bl_addr, bl_pre_op_en, bl_addr_op_en, bl_assert_en);
        end
    endtask

    initial begin
        int e0, a, a2, a3, d, b;
        repeat (3) @(negedge sys_clk);
        chk_zero("reset_state");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        // 1: write-set, single pulse
        cmd(1, 1, 5'h13, 0, e0);
        a = e0 + 20;
        push(e0, L, 8'h00, 2'b00, 1, 5'h13);
        push(e0 + 10, LP, 8'h4D, 2'b00, 1, 5'h13);
        push(a, AA, 8'h4D, 2'b00, 1, 5'h13);
        push(a + 6, LD, 8'h00, 2'b00, 0, 5'h13);
        drop(e0);
        wait_to(e0 + 15);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid act=%b exp=1", busy);
        end
        od_at(a + 5);
        wait_to(a + 8);
        // 2: write-reset, burst of three
        cmd(1, 0, 5'h0A, 2, e0);
        a = e0 + 20;
        a2 = a + 13;
        a3 = a2 + 13;
        push(e0, L, 8'h6C, 2'b00, 1, 5'h0A);
        push(e0 + 10, LP, 8'h00, 2'b00, 1, 5'h0A);
        push(a, AA, 8'h00, 2'b00, 1, 5'h0A);
        push(a2, AA, 8'h00, 2'b00, 1, 5'h0A);
        push(a3, AA, 8'h00, 2'b00, 1, 5'h0A);
        push(a3 + 4, LD, 8'h00, 2'b00, 0, 5'h0A);
        drop(e0);
        od_at(a + 3);
        od_at(a2 + 3);
        od_at(a3 + 3);
        wait_to(a3 + 6);
        // 3: read, timeout
        cmd(0, 1, 5'h1F, 0, e0);
        a = e0 + 20;
        push(e0, L, 8'h00, 2'b00, 1, 5'h1F);
        push(e0 + 10, LP, 8'h08, 2'b00, 1, 5'h1F);
        push(a, AA, 8'h08, 2'b00, 1, 5'h1F);
        push(a + 201, LD, 8'h00, 2'b01, 0, 5'h1F);
        drop(e0);
        wait_to(a + 204);
        // 4: abort in PRE_OP with timer at 4, then a normal read
        cmd(1, 1, 5'h01, 0, e0);
        push(e0, L, 8'h00, 2'b00, 1, 5'h01);
        push(e0 + 8, LD, 8'h00, 2'b10, 0, 5'h01);
        drop(e0);
        abort_at(e0 + 7);
        wait_to(e0 + 10);
        cmd(0, 0, 5'h02, 0, e0);
        b = e0 + 20;
        push(e0, L, 8'h00, 2'b00, 1, 5'h02);
        push(e0 + 10, LP, 8'h08, 2'b00, 1, 5'h02);
        push(b, AA, 8'h08, 2'b00, 1, 5'h02);
        push(b + 2, LD, 8'h00, 2'b00, 0, 5'h02);
        drop(e0);
        od_at(b + 1);
        wait_to(b + 4);
        // 5: work_en held high, op_down coincident with timeout, back-to-back accept
        cmd(1, 1, 5'h07, 1, e0);
        a = e0 + 20;
        a2 = a + 12;
        d = a2 + 201;
        b = d + 21;
        push(e0, L, 8'h00, 2'b00, 1, 5'h07);
        push(e0 + 10, LP, 8'h4D, 2'b00, 1, 5'h07);
        push(a, AA, 8'h4D, 2'b00, 1, 5'h07);
        push(a2, AA, 8'h4D, 2'b00, 1, 5'h07);
        push(d, LD, 8'h00, 2'b00, 0, 5'h07);
        push(d + 1, L, 8'h00, 2'b00, 1, 5'h08);
        push(d + 11, LP, 8'h4D, 2'b00, 1, 5'h08);
        push(b, AA, 8'h4D, 2'b00, 1, 5'h08);
        push(b + 2, LD, 8'h00, 2'b00, 0, 5'h08);
        od_at(a + 2);
        od_at(a2 + 200);
        wait_to(d);
        bl_addr_in = 5'h08;
        rep_in = 4'd0;
        drop(d + 1);
        od_at(b + 1);
        wait_to(b + 4);
        // 6: reset mid-WAIT
        cmd(0, 0, 5'h11, 0, e0);
        a = e0 + 20;
        push(e0, L, 8'h00, 2'b00, 1, 5'h11);
        push(e0 + 10, LP, 8'h08, 2'b00, 1, 5'h11);
        push(a, AA, 8'h08, 2'b00, 1, 5'h11);
        drop(e0);
        wait_to(a + 5);
        sys_rst_n = 1'b0;
        wait_to(a + 6);
        chk_zero("reset_mid_wait");
        wait_to(a + 8);
        sys_rst_n = 1'b1;
        wait_to(a + 30);
        chk_zero("idle_after_reset");
        while (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_event cyc=%0d act=none exp_st=%b", q[0].cyc, q[0].st);
            void'(q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
